// File: rtl/reg_status_file.sv
// Purpose: architectural integer register file with per-register rename status (busy + ROB tag).
// Latency: reads are combinational (zero cycles) with commit forwarding; commit/issue update on the next rising edge.
// Backpressure: none generated; rdy_in=0 freezes all state while reads stay live.
//
// Ports:
//   clk_in, rst_in              clock, asynchronous active-low reset
//   rdy_in                      global ready; when low, no state changes
//   clear_in                    ROB flush; drops all rename state (busy bits)
//   commit_en/tag/rd/val        ROB commit bus (register-writing commits)
//   issue_en/rd/tag             rename of a destination register by the issue stage
//   rs1_addr, rs2_addr          source lookups
//   rsN_busy/tag/val            lookup result: wait on tag when busy, else use val
module reg_status_file #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int TAG_W   = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              commit_en,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic [REG_AW-1:0] commit_rd,
    input  logic [XLEN-1:0]   commit_val,
    input  logic              issue_en,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic [TAG_W-1:0]  rs1_tag,
    output logic [XLEN-1:0]   rs1_val,
    output logic              rs2_busy,
    output logic [TAG_W-1:0]  rs2_tag,
    output logic [XLEN-1:0]   rs2_val
);

    logic [XLEN-1:0]  val_q  [REG_NUM];
    logic [TAG_W-1:0] tag_q  [REG_NUM];
    logic [REG_NUM-1:0] busy_q;

    logic commit_wr;
    logic issue_wr;

    // x0 is never written or renamed, so entry 0 keeps its reset value forever.
    assign commit_wr = commit_en && (commit_rd != '0);
    assign issue_wr  = issue_en && (issue_rd != '0) && !clear_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (rdy_in) begin
            if (commit_wr) begin
                val_q[commit_rd] <= commit_val;
                // Only the rename this commit belongs to may release the register;
                // a younger rename keeps it busy.
                if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag)) begin
                    busy_q[commit_rd] <= 1'b0;
                end
            end
            if (clear_in) begin
                busy_q <= '0;
            end else if (issue_wr) begin
                // Placed after the commit update so a same-cycle rename of the
                // committing register wins and leaves it busy on the new tag.
                busy_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]  <= issue_tag;
            end
        end
    end

    // Lookups forward a matching commit but never a same-cycle issue; the issue
    // stage resolves dependencies inside its own bundle.
    always_comb begin
        rs1_busy = busy_q[rs1_addr];
        rs1_tag  = tag_q[rs1_addr];
        rs1_val  = val_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_busy = 1'b0;
            rs1_val  = '0;
        end else if (busy_q[rs1_addr] && commit_en && (commit_rd == rs1_addr)
                     && (commit_tag == tag_q[rs1_addr])) begin
            rs1_busy = 1'b0;
            rs1_val  = commit_val;
        end
    end

    always_comb begin
        rs2_busy = busy_q[rs2_addr];
        rs2_tag  = tag_q[rs2_addr];
        rs2_val  = val_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_busy = 1'b0;
            rs2_val  = '0;
        end else if (busy_q[rs2_addr] && commit_en && (commit_rd == rs2_addr)
                     && (commit_tag == tag_q[rs2_addr])) begin
            rs2_busy = 1'b0;
            rs2_val  = commit_val;
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: rename, commit, forwarding, stale commits,
// same-cycle collisions, flush, x0, rdy_in hold and asynchronous reset.
module tb_reg_status_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        commit_en;
    logic [4:0]  commit_tag;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_tag;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic [4:0]  rs1_tag;
    logic [31:0] rs1_val;
    logic        rs2_busy;
    logic [4:0]  rs2_tag;
    logic [31:0] rs2_val;

    int n_checks = 0;
    int n_fail   = 0;

    reg_status_file dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear_in   (clear_in),
        .commit_en  (commit_en),
        .commit_tag (commit_tag),
        .commit_rd  (commit_rd),
        .commit_val (commit_val),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
        .issue_tag  (issue_tag),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs1_tag    (rs1_tag),
        .rs1_val    (rs1_val),
        .rs2_busy   (rs2_busy),
        .rs2_tag    (rs2_tag),
        .rs2_val    (rs2_val)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", name, obs, exp);
        end
    endtask

    // Advance past the next rising edge, leaving time to drive and then sample.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        commit_en = 1'b0;
        issue_en  = 1'b0;
        clear_in  = 1'b0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [4:0] tag);
        issue_en  = 1'b1;
        issue_rd  = rd;
        issue_tag = tag;
        tick();
        issue_en  = 1'b0;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
        commit_en = 1'b0; commit_tag = '0; commit_rd = '0; commit_val = '0;
        issue_en = 1'b0; issue_rd = '0; issue_tag = '0;
        rs1_addr = 5'd5; rs2_addr = 5'd17;

        // Reset state
        #2;
        chk("reset_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        chk("reset_rs1_val", rs1_val, 32'd0);
        chk("reset_rs1_tag", {27'd0, rs1_tag}, 32'd0);
        chk("reset_rs2_val", rs2_val, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();

        // Rename rd=5 tag=3; a same-cycle issue is not visible on reads
        issue_en = 1'b1; issue_rd = 5'd5; issue_tag = 5'd3;
        #1;
        chk("issue_no_fwd_busy", {31'd0, rs1_busy}, 32'd0);
        tick();
        issue_en = 1'b0;
        #1;
        chk("rename_busy", {31'd0, rs1_busy}, 32'd1);
        chk("rename_tag", {27'd0, rs1_tag}, 32'd3);

        // Commit tag=3 rd=5 with forwarding
        commit_en = 1'b1; commit_tag = 5'd3; commit_rd = 5'd5; commit_val = 32'hDEADBEEF;
        #1;
        chk("fwd_busy", {31'd0, rs1_busy}, 32'd0);
        chk("fwd_val", rs1_val, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        chk("commit_busy", {31'd0, rs1_busy}, 32'd0);
        chk("commit_val", rs1_val, 32'hDEADBEEF);

        // Stale commit: rd=7 renamed to tag 2 then 9
        rs2_addr = 5'd7;
        do_issue(5'd7, 5'd2);
        do_issue(5'd7, 5'd9);
        commit_en = 1'b1; commit_tag = 5'd2; commit_rd = 5'd7; commit_val = 32'h11;
        #1;
        chk("stale_nofwd_busy", {31'd0, rs2_busy}, 32'd1);
        chk("stale_nofwd_tag", {27'd0, rs2_tag}, 32'd9);
        tick();
        idle();
        #1;
        chk("stale_busy", {31'd0, rs2_busy}, 32'd1);
        chk("stale_tag", {27'd0, rs2_tag}, 32'd9);
        chk("stale_val", rs2_val, 32'h11);
        commit_en = 1'b1; commit_tag = 5'd9; commit_rd = 5'd7; commit_val = 32'h22;
        #1;
        chk("young_fwd_val", rs2_val, 32'h22);
        tick();
        idle();
        #1;
        chk("young_busy", {31'd0, rs2_busy}, 32'd0);
        chk("young_val", rs2_val, 32'h22);

        // Same-cycle commit and issue to rd=4
        rs1_addr = 5'd4;
        do_issue(5'd4, 5'd1);
        commit_en = 1'b1; commit_tag = 5'd1; commit_rd = 5'd4; commit_val = 32'h55;
        issue_en = 1'b1; issue_rd = 5'd4; issue_tag = 5'd6;
        #1;
        chk("coll_fwd_busy", {31'd0, rs1_busy}, 32'd0);
        chk("coll_fwd_val", rs1_val, 32'h55);
        tick();
        idle();
        #1;
        chk("coll_busy", {31'd0, rs1_busy}, 32'd1);
        chk("coll_tag", {27'd0, rs1_tag}, 32'd6);
        chk("coll_val", rs1_val, 32'h55);

        // Flush with simultaneous commit and issue
        do_issue(5'd1, 5'd10);
        do_issue(5'd2, 5'd11);
        do_issue(5'd31, 5'd12);
        rs1_addr = 5'd31;
        #1;
        chk("pre_flush_busy31", {31'd0, rs1_busy}, 32'd1);
        clear_in = 1'b1;
        commit_en = 1'b1; commit_tag = 5'd0; commit_rd = 5'd2; commit_val = 32'h77;
        issue_en = 1'b1; issue_rd = 5'd3; issue_tag = 5'd13;
        tick();
        idle();
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        #1;
        chk("flush_busy1", {31'd0, rs1_busy}, 32'd0);
        chk("flush_busy2", {31'd0, rs2_busy}, 32'd0);
        chk("flush_val2", rs2_val, 32'h77);
        rs1_addr = 5'd3; rs2_addr = 5'd31;
        #1;
        chk("flush_busy3", {31'd0, rs1_busy}, 32'd0);
        chk("flush_busy31", {31'd0, rs2_busy}, 32'd0);
        rs1_addr = 5'd4;
        #1;
        chk("flush_busy4", {31'd0, rs1_busy}, 32'd0);

        // x0 never written or renamed
        rs1_addr = 5'd0;
        commit_en = 1'b1; commit_tag = 5'd5; commit_rd = 5'd0; commit_val = 32'hFFFF;
        issue_en = 1'b1; issue_rd = 5'd0; issue_tag = 5'd5;
        tick();
        idle();
        #1;
        chk("x0_busy", {31'd0, rs1_busy}, 32'd0);
        chk("x0_val", rs1_val, 32'd0);

        // rdy_in=0 holds all state
        rs1_addr = 5'd8;
        commit_en = 1'b1; commit_tag = 5'd0; commit_rd = 5'd8; commit_val = 32'h1234;
        tick();
        rdy_in = 1'b0;
        commit_val = 32'h0BAD;
        issue_en = 1'b1; issue_rd = 5'd8; issue_tag = 5'd7;
        tick();
        idle();
        rdy_in = 1'b1;
        #1;
        chk("hold_val8", rs1_val, 32'h1234);
        chk("hold_busy8", {31'd0, rs1_busy}, 32'd0);

        // Asynchronous reset mid-run
        do_issue(5'd9, 5'd3);
        rs1_addr = 5'd9; rs2_addr = 5'd8;
        #1;
        chk("pre_rst_busy9", {31'd0, rs1_busy}, 32'd1);
        #1;
        rst_in = 1'b0;
        #1;
        chk("arst_busy9", {31'd0, rs1_busy}, 32'd0);
        chk("arst_tag9", {27'd0, rs1_tag}, 32'd0);
        chk("arst_val8", rs2_val, 32'd0);
        rs1_addr = 5'd5; rs2_addr = 5'd4;
        #1;
        chk("arst_val5", rs1_val, 32'd0);
        chk("arst_val4", rs2_val, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural integer register file plus per-register rename status (busy bit and ROB tag) for the out-of-order core.
- Sits directly downstream of the reorder buffer and consumes its commit bus (commit enable, ROB number, destination register, value) and its flush pulse.
- Also serves the issue stage: it records the rename of each issued rd, and answers rs1/rs2 lookups with either a ready value or the ROB tag to wait on.

Parameters:
- XLEN, 32, data width of each register and of commit values.
- REG_NUM, 32, number of architectural registers; index 0 is hardwired zero.
- REG_AW, 5, register index width (log2 REG_NUM).
- TAG_W, 5, ROB tag width; must match the ROB entry index width.

Ports:
- clk_in  in  1  single clock; all state updates on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; when 0, no state changes.
- clear_in  in  1  ROB flush pulse; clears all rename state.
- commit_en  in  1  ROB commit valid (register-writing commit).
- commit_tag  in  TAG_W  ROB number of the committing entry.
- commit_rd  in  REG_AW  destination register of the commit.
- commit_val  in  XLEN  value to write.
- issue_en  in  1  issue stage is renaming a destination this cycle.
- issue_rd  in  REG_AW  destination register being renamed.
- issue_tag  in  TAG_W  ROB entry allocated to that instruction.
- rs1_addr  in  REG_AW  source 1 index.
- rs2_addr  in  REG_AW  source 2 index.
- rs1_busy  out  1  1 means rs1 must wait on rs1_tag.
- rs1_tag  out  TAG_W  producing ROB entry for rs1 (valid when busy).
- rs1_val  out  XLEN  rs1 value (valid when not busy).
- rs2_busy  out  1  same as rs1_busy, for rs2.
- rs2_tag  out  TAG_W  same as rs1_tag, for rs2.
- rs2_val  out  XLEN  same as rs1_val, for rs2.

Behaviour:
- State per register i: val[i] (XLEN bits), busy[i], tag[i] (TAG_W bits).
- Reset (rst_in=0, asynchronous):
  - all val=0, busy=0, tag=0, effective immediately.
  - Read outputs therefore show busy=0, val=0, tag=0 for every address.
- rdy_in=0: every register holds; read outputs stay combinational.

Commit (rising edge, rdy_in=1, commit_en=1, commit_rd!=0):
- Write commit_val into val[commit_rd].
- Clear busy[commit_rd] only if busy[commit_rd]=1 and tag[commit_rd]==commit_tag. A younger rename keeps the register busy.

Issue (rising edge, rdy_in=1, issue_en=1, issue_rd!=0, clear_in=0):
- Set busy[issue_rd]=1 and tag[issue_rd]=issue_tag.

Same-cycle and boundary cases:
- Commit and issue to the same rd in one cycle: the value is written, and the issue wins, so busy=1 with tag=issue_tag.
- clear_in=1 (rdy_in=1):
  - Any simultaneous commit is still written to val.
  - Then every busy bit is forced to 0 and the issue request is ignored.
  - tag contents are don't-care after a clear.
- Register 0 is never written and never busy; writes and renames to x0 are dropped.

Reads (combinational, zero latency):
- addr==0: busy=0, val=0.
- Else if busy[addr]=1, commit_en=1, commit_rd==addr and commit_tag==tag[addr]: busy=0, val=commit_val (commit forwarding).
- Else: busy=busy[addr], tag=tag[addr], val=val[addr].
- Read forwarding never reflects a same-cycle issue. The issue stage resolves intra-bundle dependencies itself.

Widths:
- Tags compare exactly on TAG_W bits; there is no wrap logic. The ROB guarantees no two in-flight entries share a tag.

Test Plan:
- Reset: hold rst_in=0 mid-run after writes -> all reads give busy=0, val=0 immediately, without waiting for a clock edge.
- Rename then commit: issue rd=5, tag=3; next cycle read rs1=5 -> busy=1, tag=3. Then commit tag=3, rd=5, val=0xDEADBEEF -> during that cycle rs1 gives busy=0, val=0xDEADBEEF via forwarding; next cycle the stored val=0xDEADBEEF and busy=0.
- Stale commit: issue rd=7 tag=2, then issue rd=7 tag=9; commit tag=2 rd=7 val=0x11 -> val[7]=0x11, but busy stays 1 with tag=9. Later commit tag=9 val=0x22 -> busy=0, val=0x22.
- Same-cycle collision: busy[4]=1 tag=1; commit tag=1 rd=4 val=0x55 together with issue rd=4 tag=6 -> busy=1, tag=6, val[4]=0x55.
- Flush: busy on regs 1, 2 and 31; pulse clear_in with commit rd=2 val=0x77 and issue rd=3 -> all busy=0, val[2]=0x77, reg 3 not busy.
- x0 and rdy_in:
  - Issue and commit to rd=0 with val=0xFFFF -> a read of 0 gives busy=0, val=0.
  - With rdy_in=0, a commit of rd=8 -> val[8] is unchanged.
